otter_redirect_ctrl: RTL and testbench

Pipeline control-flow redirect controller for the pipelined OTTER MCU. It consumes the 3-bit PC-source decision produced in EX by the branch condition generator. It captures the taken target, handshakes the redirect into the fetch stage's PC register, and sequences the IF/ID and ID/EX flushes until every wrong-path fetch has drained. It sits between EX-stage branch resolution and the PC/fetch unit.

---
 rtl/otter_redirect_ctrl.sv | 116 +++++++++++
 tb/tb_otter_redirect_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_redirect_ctrl.sv
// Control-flow redirect controller for the pipelined OTTER: captures the EX-stage target,
// handshakes it into fetch and flushes IF/ID, ID/EX until wrong-path fetches drain. Optional stats: OTTER_REDIRECT_STATS_EN.
module otter_redirect_ctrl #(
   parameter int unsigned FETCH_LAT = 1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        ex_valid,
   input  logic [2:0]  ex_pc_source,
   input  logic [31:0] ex_jalr_tgt,
   input  logic [31:0] ex_branch_tgt,
   input  logic [31:0] ex_jal_tgt,
   input  logic        redirect_ack,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        redirect_misaligned,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        busy,
   output logic [31:0] stat_redirects,
   output logic [31:0] stat_wait_cycles
);

   typedef enum logic [1:0] {RUN, REDIRECT, DRAIN} state_t;

   localparam logic [1:0] LAT = FETCH_LAT[1:0];

   state_t      state, state_nxt;
   logic [1:0]  drain_cnt, drain_cnt_nxt;
   logic        ev;
   logic [31:0] tgt_sel;

   // Instructions reaching EX outside RUN are wrong-path, so only RUN can raise an event.
   always_comb begin
      ev = 1'b0;
      if (ex_valid && (state == RUN))
         ev = (ex_pc_source == 3'b001) || (ex_pc_source == 3'b010) || (ex_pc_source == 3'b011);
   end

   always_comb begin
      tgt_sel = ex_branch_tgt;
      case (ex_pc_source)
         3'b001:  tgt_sel = ex_jalr_tgt & ~32'h1;
         3'b011:  tgt_sel = ex_jal_tgt;
         default: tgt_sel = ex_branch_tgt;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= RUN;
         drain_cnt   <= 2'd0;
         redirect_pc <= 32'h0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         if (ev)
            redirect_pc <= tgt_sel;
      end
   end

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      case (state)
         RUN: begin
            if (ev)
               state_nxt = REDIRECT;
         end
         REDIRECT: begin
            if (redirect_ack) begin
               state_nxt     = (LAT == 2'd0) ? RUN : DRAIN;
               drain_cnt_nxt = LAT;
            end
         end
         DRAIN: begin
            drain_cnt_nxt = drain_cnt - 2'd1;
            if (drain_cnt <= 2'd1)
               state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      redirect_valid      = (state == REDIRECT);
      redirect_misaligned = (state == REDIRECT) && redirect_pc[1];
      flush_idex          = ev || (state == REDIRECT);
      flush_ifid          = ev || (state == REDIRECT) || (state == DRAIN);
      busy                = (state != RUN);
   end

`ifdef OTTER_REDIRECT_STATS_EN
   logic [31:0] stat_redirects_q, stat_wait_q;

   // Free-running wrap on both counters.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stat_redirects_q <= 32'h0;
         stat_wait_q      <= 32'h0;
      end else if (state == REDIRECT) begin
         if (redirect_ack)
            stat_redirects_q <= stat_redirects_q + 32'd1;
         else
            stat_wait_q <= stat_wait_q + 32'd1;
      end
   end

   assign stat_redirects   = stat_redirects_q;
   assign stat_wait_cycles = stat_wait_q;
`else
   assign stat_redirects   = 32'h0;
   assign stat_wait_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_otter_redirect_ctrl.sv
// Bench for otter_redirect_ctrl: directed scenarios plus random traffic against a
// transaction-level model, on a FETCH_LAT=1 and a FETCH_LAT=0 instance.
module tb_otter_redirect_ctrl;

`ifdef OTTER_REDIRECT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        CLK, RST_N;
   logic        ex_valid, redirect_ack;
   logic [2:0]  ex_pc_source;
   logic [31:0] ex_jalr_tgt, ex_branch_tgt, ex_jal_tgt;

   logic        rv1, mis1, ifid1, idex1, busy1;
   logic [31:0] pc1, sr1, sw1;
   logic        rv0, mis0, ifid0, idex0, busy0;
   logic [31:0] pc0, sr0, sw0;

   int total = 0;
   int bad   = 0;

   otter_redirect_ctrl #(.FETCH_LAT(1)) dut (
      .CLK(CLK), .RST_N(RST_N), .ex_valid(ex_valid), .ex_pc_source(ex_pc_source),
      .ex_jalr_tgt(ex_jalr_tgt), .ex_branch_tgt(ex_branch_tgt), .ex_jal_tgt(ex_jal_tgt),
      .redirect_ack(redirect_ack), .redirect_valid(rv1), .redirect_pc(pc1),
      .redirect_misaligned(mis1), .flush_ifid(ifid1), .flush_idex(idex1), .busy(busy1),
      .stat_redirects(sr1), .stat_wait_cycles(sw1));

   otter_redirect_ctrl #(.FETCH_LAT(0)) dut0 (
      .CLK(CLK), .RST_N(RST_N), .ex_valid(ex_valid), .ex_pc_source(ex_pc_source),
      .ex_jalr_tgt(ex_jalr_tgt), .ex_branch_tgt(ex_branch_tgt), .ex_jal_tgt(ex_jal_tgt),
      .redirect_ack(redirect_ack), .redirect_valid(rv0), .redirect_pc(pc0),
      .redirect_misaligned(mis0), .flush_ifid(ifid0), .flush_idex(idex0), .busy(busy0),
      .stat_redirects(sr0), .stat_wait_cycles(sw0));

   logic [100:0] obs [2];
   assign obs[0] = {rv1, pc1, mis1, ifid1, idex1, busy1, sr1, sw1};
   assign obs[1] = {rv0, pc0, mis0, ifid0, idex0, busy0, sr0, sw0};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: a pending target plus a count of wrong-path fetches still in flight.
   int          lat [2] = '{1, 0};
   bit          m_pend [2];
   logic [31:0] m_pc [2];
   int          m_drain [2];
   logic [31:0] m_red [2], m_wait [2];

   function automatic bit m_ev(int k);
      return ex_valid && !m_pend[k] && (m_drain[k] == 0) &&
             (ex_pc_source >= 3'd1) && (ex_pc_source <= 3'd3);
   endfunction

   function automatic logic [31:0] m_tgt();
      if (ex_pc_source == 3'd1) return {ex_jalr_tgt[31:1], 1'b0};
      if (ex_pc_source == 3'd2) return ex_branch_tgt;
      return ex_jal_tgt;
   endfunction

   function automatic logic [100:0] m_exp(int k);
      bit e = m_ev(k);
      return {m_pend[k], m_pc[k], m_pend[k] & m_pc[k][1], e | m_pend[k] | (m_drain[k] > 0),
              e | m_pend[k], m_pend[k] | (m_drain[k] > 0),
              STATS ? m_red[k] : 32'h0, STATS ? m_wait[k] : 32'h0};
   endfunction

   always @(posedge CLK or negedge RST_N) begin
      for (int k = 0; k < 2; k++) begin
         if (!RST_N) begin
            m_pend[k] = 1'b0; m_pc[k] = 32'h0; m_drain[k] = 0;
            m_red[k] = 32'h0; m_wait[k] = 32'h0;
         end else if (m_ev(k)) begin
            m_pend[k] = 1'b1;
            m_pc[k]   = m_tgt();
         end else if (m_pend[k]) begin
            if (redirect_ack) begin
               m_pend[k]  = 1'b0;
               m_drain[k] = lat[k];
               m_red[k]   = m_red[k] + 32'd1;
            end else begin
               m_wait[k] = m_wait[k] + 32'd1;
            end
         end else if (m_drain[k] > 0) begin
            m_drain[k] = m_drain[k] - 1;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      ex_valid = 1'b0; ex_pc_source = 3'd0; redirect_ack = 1'b0;
      ex_jalr_tgt = 32'h0; ex_branch_tgt = 32'h0; ex_jal_tgt = 32'h0;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      #2 RST_N = 1'b0;
      idle_inputs();
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs[k] !== '0) begin
            bad++;
            $display("FAIL reset_outputs dut%0d got=%h want=0", k, obs[k]);
         end
      end
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
   endtask

   task automatic test_taken_beq();
      test_reset();
      ex_valid = 1'b1; ex_pc_source = 3'b010; ex_branch_tgt = 32'h100; redirect_ack = 1'b1;
      @(negedge CLK);
      total++;
      if ({ifid1, idex1, rv1} !== 3'b110) begin
         bad++; $display("FAIL beq_event_flush got=%b want=110", {ifid1, idex1, rv1});
      end
      tick();
      ex_valid = 1'b0;
      @(negedge CLK);
      total++;
      if ({rv1, pc1, ifid1, idex1} !== {1'b1, 32'h100, 2'b11}) begin
         bad++; $display("FAIL beq_redirect got rv=%b pc=%h want rv=1 pc=100", rv1, pc1);
      end
      tick();
      redirect_ack = 1'b0;
      @(negedge CLK);
      total++;
      if ({rv1, ifid1, idex1, busy1} !== 4'b0101) begin
         bad++; $display("FAIL beq_drain got=%b want=0101", {rv1, ifid1, idex1, busy1});
      end
      tick();
      @(negedge CLK);
      total++;
      if ({busy1, ifid1, sr1} !== {2'b00, STATS ? 32'd1 : 32'd0}) begin
         bad++; $display("FAIL beq_run got busy=%b ifid=%b stat=%0d", busy1, ifid1, sr1);
      end
      tick();
   endtask

   task automatic test_jalr_stall();
      int idex_cnt = 0;
      test_reset();
      ex_valid = 1'b1; ex_pc_source = 3'b001; ex_jalr_tgt = 32'h203;
      @(negedge CLK);
      idex_cnt += int'(idex1);
      tick();
      ex_valid = 1'b0;
      for (int w = 0; w < 4; w++) begin
         redirect_ack = (w == 3);
         @(negedge CLK);
         idex_cnt += int'(idex1);
         total++;
         if ({rv1, pc1, mis1} !== {1'b1, 32'h202, 1'b1}) begin
            bad++; $display("FAIL jalr_hold cyc%0d got rv=%b pc=%h mis=%b want 1/202/1", w, rv1, pc1, mis1);
         end
         tick();
      end
      redirect_ack = 1'b0;
      @(negedge CLK);
      idex_cnt += int'(idex1);
      total++;
      if (idex_cnt != 5 || sw1 !== (STATS ? 32'd3 : 32'd0)) begin
         bad++; $display("FAIL jalr_counts got idex=%0d wait=%0d want idex=5", idex_cnt, sw1);
      end
      tick();
      tick();
   endtask

   task automatic test_wrong_path();
      test_reset();
      ex_valid = 1'b1; ex_pc_source = 3'b010; ex_branch_tgt = 32'h300;
      tick();
      ex_pc_source = 3'b011; ex_jal_tgt = 32'h400;
      @(negedge CLK);
      total++;
      if ({rv1, pc1, ifid1, idex1} !== {1'b1, 32'h300, 2'b11}) begin
         bad++; $display("FAIL wp_hold got rv=%b pc=%h", rv1, pc1);
      end
      tick();
      redirect_ack = 1'b1;
      tick();
      redirect_ack = 1'b0;
      @(negedge CLK);
      total++;
      if ({rv1, busy1, pc1} !== {2'b01, 32'h300}) begin
         bad++; $display("FAIL wp_drain got rv=%b busy=%b pc=%h want 0/1/300", rv1, busy1, pc1);
      end
      tick();
      ex_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         total++;
         if ({rv1, busy1, pc1} !== {2'b00, 32'h300}) begin
            bad++; $display("FAIL wp_no_second cyc%0d got rv=%b busy=%b pc=%h", c, rv1, busy1, pc1);
         end
         tick();
      end
   endtask

   task automatic test_reserved();
      logic [2:0] codes [4] = '{3'b000, 3'b110, 3'b100, 3'b111};
      test_reset();
      ex_valid = 1'b1; ex_branch_tgt = 32'h500; ex_jal_tgt = 32'h600; ex_jalr_tgt = 32'h700;
      for (int i = 0; i < 4; i++) begin
         ex_pc_source = codes[i];
         @(negedge CLK);
         total++;
         if ({ifid1, idex1, busy1, rv1, ifid0, busy0} !== 6'b0) begin
            bad++; $display("FAIL reserved code=%b got=%b want=0", codes[i], {ifid1, idex1, busy1, rv1, ifid0, busy0});
         end
         tick();
      end
      ex_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      test_reset();
      ex_valid = 1'b1; ex_pc_source = 3'b011; ex_jal_tgt = 32'h500;
      tick();
      ex_valid = 1'b0;
      #2;
      total++;
      if (rv1 !== 1'b1) begin
         bad++; $display("FAIL rmid_pre got rv=%b want=1", rv1);
      end
      RST_N = 1'b0;
      #1;
      total++;
      if (obs[0] !== '0 || obs[1] !== '0) begin
         bad++; $display("FAIL rmid_async got=%h / %h want=0", obs[0], obs[1]);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      ex_valid = 1'b1; ex_jal_tgt = 32'h80;
      @(negedge CLK);
      total++;
      if ({ifid1, idex1, rv1} !== 3'b110) begin
         bad++; $display("FAIL rmid_fresh_ev got=%b want=110", {ifid1, idex1, rv1});
      end
      tick();
      ex_valid = 1'b0; redirect_ack = 1'b1;
      @(negedge CLK);
      total++;
      if ({rv1, pc1} !== {1'b1, 32'h80}) begin
         bad++; $display("FAIL rmid_fresh_pc got rv=%b pc=%h want 1/80", rv1, pc1);
      end
      tick();
      redirect_ack = 1'b0;
      tick();
   endtask

   task automatic test_fetch_lat0();
      int ifid_cnt = 0;
      test_reset();
`ifdef OTTER_REDIRECT_STATS_EN
      force dut0.stat_redirects_q = 32'hFFFF_FFFF;
      #1 release dut0.stat_redirects_q;
`endif
      ex_valid = 1'b1; ex_pc_source = 3'b010; ex_branch_tgt = 32'h40;
      @(negedge CLK);
      ifid_cnt += int'(ifid0);
      tick();
      ex_valid = 1'b0; redirect_ack = 1'b1;
      @(negedge CLK);
      ifid_cnt += int'(ifid0);
      total++;
      if ({rv0, pc0} !== {1'b1, 32'h40}) begin
         bad++; $display("FAIL lat0_redirect got rv=%b pc=%h want 1/40", rv0, pc0);
      end
      tick();
      redirect_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         ifid_cnt += int'(ifid0);
         tick();
      end
      total++;
      if (ifid_cnt != 2 || busy0 !== 1'b0) begin
         bad++; $display("FAIL lat0_flush got ifid_cycles=%0d busy=%b want 2/0", ifid_cnt, busy0);
      end
      total++;
      if (sr0 !== 32'h0) begin
         bad++; $display("FAIL lat0_stat_wrap got=%h want=0", sr0);
      end
   endtask

   task automatic test_random();
      test_reset();
      for (int c = 0; c < 800; c++) begin
         if (c == 400) test_reset();
         ex_valid      = ($urandom_range(0, 9) < 7);
         ex_pc_source  = 3'($urandom_range(0, 7));
         ex_jalr_tgt   = $urandom;
         ex_branch_tgt = $urandom;
         ex_jal_tgt    = $urandom;
         redirect_ack  = ($urandom_range(0, 2) == 0);
         @(negedge CLK);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== m_exp(k)) begin
               bad++;
               $display("FAIL random cyc%0d dut%0d got=%h want=%h", c, k, obs[k], m_exp(k));
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      RST_N = 1'b1;
      idle_inputs();
      test_reset();
      test_taken_beq();
      test_jalr_stall();
      test_wrong_path();
      test_reserved();
      test_reset_mid();
      test_fetch_lat0();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
